// File: rtl/pc_fetch_unit.sv
// Program-counter fetch stage with a run/halt/fault FSM and a count of retired instructions.
// Optional macro PC_BOUNDS_CHECK_EN also faults on fetch targets past the end of instruction memory.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Immediate,
  input  logic [25:0] JumpAddr,
  input  logic [31:0] RegAddr,
  input  logic        Halt,
  output logic [31:0] PCLine,
  output logic [31:0] PCPlus4,
  output logic [1:0]  State,
  output logic        Fault,
  output logic [31:0] InstCount
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HALT  = 2'b01,
    FAULT = 2'b10,
    BAD   = 2'b11
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
`ifdef PC_BOUNDS_CHECK_EN
  localparam logic CHECK_RANGE = 1'b1;
`else
  localparam logic CHECK_RANGE = 1'b0;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] count;
  logic        fault_q;
  logic [31:0] next_pc;
  logic        bad_target;

  assign PCPlus4 = pc + 32'd4;

  always_comb begin
    next_pc = PCPlus4;
    case (PCSrc)
      2'b00: next_pc = PCPlus4;
      2'b01: next_pc = PCPlus4 + {Immediate[29:0], 2'b00};
      2'b10: next_pc = {PCPlus4[31:28], JumpAddr, 2'b00};
      2'b11: next_pc = RegAddr;
      default: next_pc = PCPlus4;
    endcase
  end

  // With the range check compiled out CHECK_RANGE is constant 0 and the compare folds away.
  assign bad_target = (next_pc[1:0] != 2'b00) || (CHECK_RANGE && (next_pc > LAST_PC));

  // HALT and FAULT are terminal; only the asynchronous reset leaves them.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      count   <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (Halt) begin
            state <= HALT;
          end else if (PCWre) begin
            if (bad_target) begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end else begin
              pc    <= next_pc;
              count <= count + 32'd1;
            end
          end
        end
        HALT:  state <= HALT;
        FAULT: state <= FAULT;
        default: begin
          state   <= FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign PCLine    = pc;
  assign State     = state;
  assign Fault     = fault_q;
  assign InstCount = count;

endmodule
